seven_segment_decoder: RTL
==========================

# seven_segment_decoder

Loopback monitor that samples the multiplexed seven-segment bus (active-low segments, active-low anodes) and rebuilds the four displayed hex digits. It sits on the Basys3 wrapper beside `seven_segment_driver`, taps the same `seg`/`an` nets, and feeds the self-test logic and the ILA. Each digit is accepted only after its anode/segment pattern has been stable for a set time. Each digit also carries valid, blank and error status, and goes stale after a refresh timeout.

## Interface
- `STABLE_CYCLES`, default 16: consecutive unchanged cycles required before capture. Legal range ≥1.
- `TIMEOUT_CYCLES`, default 1_000_000: cycles without a capture before a digit's valid flag drops. Legal range ≥2.
- `clk`, input, 1: clock.
- `reset_n`, input, 1: reset, synchronous, active-low; clock clk.
- `seg_in`, input, 7: segment bus, active-low, bit 0 = segment a.
- `an_in`, input, 4: anode bus, active-low, bit i = digit i.
- `dig`, output, [3:0] array of 4 bits: decoded hex value per digit.
- `dig_valid`, output, 4: digit i holds a fresh, legal hex glyph.
- `dig_blank`, output, 4: last capture for digit i was 7'b1111111.
- `seg_err`, output, 4: last capture for digit i was not a hex glyph and not blank.
- `frame_done`, output, 1: one-cycle pulse once all four digits have been captured since the previous pulse.

## Operation
- **Sample stage.** Every cycle, register `s <= {an_in, seg_in}`. Update `cnt <= ({an_in,seg_in} != s) ? 0 : min(cnt+1, STABLE_CYCLES)`. Any change also clears `captured`.
- **Capture condition.** Capture fires when `cnt == STABLE_CYCLES`, `captured == 0`, and `s.an` has exactly one zero bit; that bit gives index i. Capture sets `captured`, so there is one capture per stable period.
- **No-capture cases.**
  - `an == 4'b1111`: idle, never captured.
  - Two or more zero bits in `an`: ignored; no flags change.
- **Glyph decode.** Decode is the inverse of the team hex table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
- **Capture result for digit i.**
  - Legal glyph: `dig[i]` = value, `dig_valid[i]`=1, `dig_blank[i]`=0, `seg_err[i]`=0.
  - Blank (1111111): `dig[i]` retained, `dig_valid[i]`=0, `dig_blank[i]`=1, `seg_err[i]`=0.
  - Any other pattern: `dig[i]` retained, `dig_valid[i]`=0, `dig_blank[i]`=0, `seg_err[i]`=1.
- **Age counters.** Each digit has an age counter of width $clog2(TIMEOUT_CYCLES).
  - A capture of digit i resets `age[i]` to 0.
  - Otherwise `age[i]` increments, saturating at `TIMEOUT_CYCLES-1`.
  - When `age[i]` reaches `TIMEOUT_CYCLES-1`, `dig_valid[i]` clears. `dig`, `dig_blank` and `seg_err` are held.
- **Frame tracking.** A `seen[3:0]` mask sets bit i on any capture of i (legal, blank or error). When a capture makes `seen` all-ones, `frame_done` pulses and `seen` clears to 0 in the same update; the completing digit is not carried into the next frame.

## Timing
- **Reset values.** All outputs: `dig` all 0, `dig_valid`/`dig_blank`/`seg_err` = 0, `frame_done` = 0. Internal state: `s` = {4'b1111, 7'b1111111}, `cnt` = 0, `captured` = 0, `age` = 0, `seen` = 0.
- **Capture latency.** New value first registered into `s` at edge E0. `cnt` reaches `STABLE_CYCLES` at E0+STABLE_CYCLES. Outputs update at edge E0+STABLE_CYCLES+1; with the default of 16 this is 17 edges.
- **Glitch rejection.** A pattern held for fewer than STABLE_CYCLES+1 sampled cycles produces no capture and no output change.
- **`frame_done` width.** Exactly one cycle, coincident with the output update of the completing capture.
- **Capture vs. timeout.** If a capture and a timeout of the same digit occur in the same cycle, the capture wins: `dig_valid` follows the glyph and `age` = 0.
- **Outputs.** All outputs are registered; none is combinational from the inputs.
- **Reset mid-capture.** Reset during a stable period discards it. After release, the pattern must again be stable for STABLE_CYCLES+1 sampled cycles before capture.
- **Counter saturation.** `cnt` saturates, so an indefinitely held pattern captures exactly once.

## Test plan
- **Loopback.** Drive from `seven_segment_driver` (TICK_CYCLES=64, ON_FRACTION=0.25), `dig` = {F,A,3,0}, with STABLE_CYCLES=4 → `dig` = {F,A,3,0} and `dig_valid`=4'b1111 within two scan frames; `frame_done` pulses once per 4 ticks.
- **Latency and hold.** Hold `an`=1101, `seg`=0100100 from idle → `dig[1]`=2, `dig_valid[1]`=1 exactly STABLE_CYCLES+1 edges after first sample. Holding 1000 more cycles gives no further capture and no `frame_done`.
- **Glitch.** Apply `an`=1110, `seg`=1111001 for STABLE_CYCLES cycles, then `an`=1111 → no output change. Same pattern held one cycle longer → `dig[0]`=1.
- **Error and blank.** Capture `seg`=0101010 on digit 3 → `seg_err[3]`=1, `dig_valid[3]`=0, `dig[3]` unchanged. Then capture 1111111 → `dig_blank[3]`=1, `seg_err[3]`=0.
- **Timeout.** With TIMEOUT_CYCLES=100, capture digit 2 = 7, then idle → `dig_valid[2]` falls 99 cycles after the capture update; `dig[2]` stays 7. Then check a capture coinciding with the timeout cycle → `dig_valid[2]` stays 1.
- **Illegal anode and reset.**
  - `an`=1100 held 50 cycles → no flag changes.
  - Assert `reset_n`=0 mid-stable-period → all outputs 0 next edge.
  - Release → capture requires the full STABLE_CYCLES+1 again.

Source files
------------

// File: rtl/seven_segment_decoder.sv
// Loopback monitor for a multiplexed seven-segment bus: it waits for each anode/segment
// pattern to settle, then rebuilds the displayed hex digits with valid, blank, error and staleness status.
module seven_segment_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] seg_in,
  input  logic [3:0] an_in,
  output logic [3:0] dig [0:3],
  output logic [3:0] dig_valid,
  output logic [3:0] dig_blank,
  output logic [3:0] seg_err,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT_CYCLES - 2);

  logic [10:0]      bus;
  logic [10:0]      s_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             captured_reg;
  logic [3:0]       seen_reg;
  logic             frame_done_reg;
  logic [3:0]       s_an;
  logic [6:0]       s_seg;
  logic [3:0]       cap_sel;
  logic             glyph_ok;
  logic [3:0]       glyph_val;
  logic             glyph_blank;

  assign bus   = {an_in, seg_in};
  assign s_an  = s_reg[10:7];
  assign s_seg = s_reg[6:0];

  // Stability tracker: any change of the sampled bus restarts the count and re-arms capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_reg        <= 11'h7FF;
      cnt_reg      <= '0;
      captured_reg <= 1'b0;
    end else begin
      s_reg <= bus;
      if (bus != s_reg) begin
        cnt_reg      <= '0;
        captured_reg <= 1'b0;
      end else begin
        if (cnt_reg != CNT_MAX)
          cnt_reg <= cnt_reg + 1'b1;
        if (|cap_sel)
          captured_reg <= 1'b1;
      end
    end
  end

  // Exactly one active (low) anode selects the digit; idle or multi-anode patterns never capture.
  always_comb begin
    cap_sel = 4'b0000;
    if ((cnt_reg == CNT_MAX) && !captured_reg && $onehot(~s_an))
      cap_sel = ~s_an;
  end

  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    case (s_seg)
      7'b1000000: glyph_val = 4'h0;
      7'b1111001: glyph_val = 4'h1;
      7'b0100100: glyph_val = 4'h2;
      7'b0110000: glyph_val = 4'h3;
      7'b0011001: glyph_val = 4'h4;
      7'b0010010: glyph_val = 4'h5;
      7'b0000010: glyph_val = 4'h6;
      7'b1111000: glyph_val = 4'h7;
      7'b0000000: glyph_val = 4'h8;
      7'b0010000: glyph_val = 4'h9;
      7'b0001000: glyph_val = 4'hA;
      7'b0000011: glyph_val = 4'hB;
      7'b1000110: glyph_val = 4'hC;
      7'b0100001: glyph_val = 4'hD;
      7'b0000110: glyph_val = 4'hE;
      7'b0001110: glyph_val = 4'hF;
      default:    glyph_ok  = 1'b0;
    endcase
  end

  assign glyph_blank = (s_seg == 7'b1111111);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0]       dig_reg;
      logic             valid_reg;
      logic             blank_reg;
      logic             err_reg;
      logic [AGE_W-1:0] age_reg;

      // A capture takes priority over the staleness timeout in the same cycle.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          dig_reg   <= 4'h0;
          valid_reg <= 1'b0;
          blank_reg <= 1'b0;
          err_reg   <= 1'b0;
          age_reg   <= '0;
        end else if (cap_sel[gi]) begin
          age_reg <= '0;
          if (glyph_ok) begin
            dig_reg   <= glyph_val;
            valid_reg <= 1'b1;
            blank_reg <= 1'b0;
            err_reg   <= 1'b0;
          end else if (glyph_blank) begin
            valid_reg <= 1'b0;
            blank_reg <= 1'b1;
            err_reg   <= 1'b0;
          end else begin
            valid_reg <= 1'b0;
            blank_reg <= 1'b0;
            err_reg   <= 1'b1;
          end
        end else if (age_reg >= AGE_LAST) begin
          age_reg   <= AGE_MAX;
          valid_reg <= 1'b0;
        end else begin
          age_reg <= age_reg + 1'b1;
        end
      end

      assign dig[gi]       = dig_reg;
      assign dig_valid[gi] = valid_reg;
      assign dig_blank[gi] = blank_reg;
      assign seg_err[gi]   = err_reg;
    end
  endgenerate

  // The completing capture closes the frame; its digit does not count toward the next one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seen_reg       <= 4'b0000;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (|cap_sel) begin
        if ((seen_reg | cap_sel) == 4'b1111) begin
          frame_done_reg <= 1'b1;
          seen_reg       <= 4'b0000;
        end else begin
          seen_reg <= seen_reg | cap_sel;
        end
      end
    end
  end

  assign frame_done = frame_done_reg;

endmodule
